// File: rtl/mem_clear_ctrl.sv
// Zero-fill sequencer: sweeps the full SDRAM and DDR3 address spaces with
// handshaked write requests, reporting busy/done/progress to the top level.
module mem_clear_ctrl #(
    parameter int unsigned SDR_AW    = 25,
    parameter int unsigned DDR_AW    = 29,
    parameter int unsigned DDR_BURST = 8
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    output logic [SDR_AW-1:0] sdr_addr,
    output logic              sdr_we,
    input  logic              sdr_ready,
    output logic [DDR_AW-1:0] ddr_addr,
    output logic [7:0]        ddr_burstcnt,
    output logic [7:0]        ddr_be,
    output logic              ddr_we,
    input  logic              ddr_busy,
    output logic              busy,
    output logic              done,
    output logic [7:0]        progress
);

    localparam int unsigned BCW = (DDR_BURST > 1) ? $clog2(DDR_BURST) : 1;

    localparam logic [SDR_AW-1:0] SDR_LAST  = '1;
    localparam logic [DDR_AW-1:0] DDR_STEP  = DDR_AW'(DDR_BURST);
    localparam logic [DDR_AW-1:0] DDR_LAST  = ~(DDR_STEP - DDR_AW'(1));
    localparam logic [BCW-1:0]    BEAT_LAST = BCW'(DDR_BURST - 1);

    typedef enum logic [1:0] {
        SDR_IDLE,
        SDR_RUN,
        SDR_DONE
    } sdr_state_t;

    typedef enum logic [1:0] {
        DDR_IDLE,
        DDR_RUN,
        DDR_DRAIN,
        DDR_DONE
    } ddr_state_t;

    sdr_state_t        sdr_state, sdr_state_n;
    ddr_state_t        ddr_state, ddr_state_n;
    logic [SDR_AW-1:0] sdr_addr_n;
    logic [DDR_AW-1:0] ddr_addr_n;
    logic [BCW-1:0]    beat_cnt, beat_cnt_n;
    logic              sdr_we_n, ddr_we_n, busy_n, done_n;
    logic [7:0]        ddr_be_n, progress_n;
    logic [7:0]        sdr_prog, ddr_prog;
    logic              start_ok, ddr_beat, burst_end;

    assign ddr_burstcnt = 8'(DDR_BURST);

    always_comb begin
        sdr_state_n = sdr_state;
        ddr_state_n = ddr_state;
        sdr_addr_n  = sdr_addr;
        ddr_addr_n  = ddr_addr;
        beat_cnt_n  = beat_cnt;

        start_ok  = start && !abort && !busy;
        ddr_beat  = ddr_we && !ddr_busy;
        burst_end = ddr_beat && (beat_cnt == BEAT_LAST);

        case (sdr_state)
            SDR_IDLE, SDR_DONE: begin
                if (start_ok) begin
                    sdr_state_n = SDR_RUN;
                    sdr_addr_n  = '0;
                end
            end
            SDR_RUN: begin
                // Completing the final word wins over a coincident abort.
                if (sdr_ready && sdr_addr == SDR_LAST) begin
                    sdr_state_n = SDR_DONE;
                end else begin
                    if (sdr_ready) begin
                        sdr_addr_n = sdr_addr + SDR_AW'(1);
                    end
                    if (abort) begin
                        sdr_state_n = SDR_IDLE;
                    end
                end
            end
            default: sdr_state_n = SDR_IDLE;
        endcase

        case (ddr_state)
            DDR_IDLE, DDR_DONE: begin
                if (start_ok) begin
                    ddr_state_n = DDR_RUN;
                    ddr_addr_n  = '0;
                    beat_cnt_n  = '0;
                end
            end
            DDR_RUN, DDR_DRAIN: begin
                if (ddr_beat) begin
                    beat_cnt_n = burst_end ? '0 : beat_cnt + BCW'(1);
                end
                if (burst_end) begin
                    if (ddr_addr == DDR_LAST) begin
                        ddr_state_n = DDR_DONE;
                    end else begin
                        ddr_addr_n = ddr_addr + DDR_STEP;
                        if (ddr_state == DDR_DRAIN || abort) begin
                            ddr_state_n = DDR_IDLE;
                        end
                    end
                end else if (ddr_state == DDR_RUN && abort) begin
                    // Stop immediately only on a burst boundary with no beat in flight.
                    if (beat_cnt == '0 && !ddr_beat) begin
                        ddr_state_n = DDR_IDLE;
                    end else begin
                        ddr_state_n = DDR_DRAIN;
                    end
                end
            end
            default: ddr_state_n = DDR_IDLE;
        endcase

        sdr_we_n = (sdr_state_n == SDR_RUN);
        ddr_we_n = (ddr_state_n == DDR_RUN) || (ddr_state_n == DDR_DRAIN);
        ddr_be_n = ddr_we_n ? 8'hFF : '0;
        busy_n   = sdr_we_n || ddr_we_n;
        done_n   = (sdr_state_n == SDR_DONE) && (ddr_state_n == DDR_DONE);

        sdr_prog   = (sdr_state_n == SDR_DONE) ? 8'hFF : sdr_addr_n[SDR_AW-1 -: 8];
        ddr_prog   = (ddr_state_n == DDR_DONE) ? 8'hFF : ddr_addr_n[DDR_AW-1 -: 8];
        progress_n = (sdr_prog < ddr_prog) ? sdr_prog : ddr_prog;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            sdr_state <= SDR_IDLE;
            ddr_state <= DDR_IDLE;
            sdr_addr  <= '0;
            ddr_addr  <= '0;
            beat_cnt  <= '0;
            sdr_we    <= 1'b0;
            ddr_we    <= 1'b0;
            ddr_be    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            progress  <= '0;
        end else begin
            sdr_state <= sdr_state_n;
            ddr_state <= ddr_state_n;
            sdr_addr  <= sdr_addr_n;
            ddr_addr  <= ddr_addr_n;
            beat_cnt  <= beat_cnt_n;
            sdr_we    <= sdr_we_n;
            ddr_we    <= ddr_we_n;
            ddr_be    <= ddr_be_n;
            busy      <= busy_n;
            done      <= done_n;
            progress  <= progress_n;
        end
    end

endmodule

// File: tb/tb_mem_clear_ctrl.sv
// Randomized self-checking bench for mem_clear_ctrl against a transaction-count
// model of both clearing channels.
module tb_mem_clear_ctrl;

    localparam int SDR_AW    = 8;
    localparam int DDR_AW    = 10;
    localparam int BURST     = 4;
    localparam int SDR_WORDS = 256;
    localparam int DDR_BEATS = 1024;

    logic              clk_sys = 1'b0;
    logic              reset   = 1'b1;
    logic              start   = 1'b0;
    logic              abort   = 1'b0;
    logic              sdr_ready = 1'b0;
    logic              ddr_busy  = 1'b0;
    logic [SDR_AW-1:0] sdr_addr;
    logic              sdr_we;
    logic [DDR_AW-1:0] ddr_addr;
    logic [7:0]        ddr_burstcnt;
    logic [7:0]        ddr_be;
    logic              ddr_we;
    logic              busy;
    logic              done;
    logic [7:0]        progress;

    mem_clear_ctrl #(
        .SDR_AW    (SDR_AW),
        .DDR_AW    (DDR_AW),
        .DDR_BURST (BURST)
    ) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .sdr_addr     (sdr_addr),
        .sdr_we       (sdr_we),
        .sdr_ready    (sdr_ready),
        .ddr_addr     (ddr_addr),
        .ddr_burstcnt (ddr_burstcnt),
        .ddr_be       (ddr_be),
        .ddr_we       (ddr_we),
        .ddr_busy     (ddr_busy),
        .busy         (busy),
        .done         (done),
        .progress     (progress)
    );

    always #5 clk_sys = ~clk_sys;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Reference model: activity flags plus words/beats written since the last start.
    bit m_sdr_act, m_sdr_fin, m_ddr_act, m_ddr_drain, m_ddr_fin;
    int m_sdr_next, m_ddr_beats;
    int obs_sdr, obs_ddr;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int exp_progress();
        int s, d;
        s = m_sdr_fin ? 255 : m_sdr_next;
        d = m_ddr_fin ? 255 : m_ddr_beats / BURST;
        return (s < d) ? s : d;
    endfunction

    task automatic model_reset();
        m_sdr_act = 0; m_sdr_fin = 0; m_sdr_next = 0;
        m_ddr_act = 0; m_ddr_drain = 0; m_ddr_fin = 0; m_ddr_beats = 0;
    endtask

    task automatic step(input bit st, input bit ab, input bit rdy, input bit bsy);
        bit s_hs, d_hs, acc, bend;
        start = st; abort = ab; sdr_ready = rdy; ddr_busy = bsy;
        s_hs = m_sdr_act && rdy;
        d_hs = m_ddr_act && !bsy;
        if (sdr_we && rdy)  obs_sdr++;
        if (ddr_we && !bsy) obs_ddr++;
        if (m_sdr_act) check_val("sdr_addr", sdr_addr, m_sdr_next);
        if (m_ddr_act) begin
            check_val("ddr_addr", ddr_addr, (m_ddr_beats / BURST) * BURST);
            check_val("ddr_be_on", ddr_be, 8'hFF);
        end
        acc = st && !ab && !(m_sdr_act || m_ddr_act);

        if (acc) begin
            m_sdr_act = 1; m_sdr_fin = 0; m_sdr_next = 0;
        end else if (m_sdr_act) begin
            if (s_hs) m_sdr_next++;
            if (s_hs && m_sdr_next == SDR_WORDS) begin
                m_sdr_act = 0; m_sdr_fin = 1;
            end else if (ab) begin
                m_sdr_act = 0;
            end
        end

        if (acc) begin
            m_ddr_act = 1; m_ddr_fin = 0; m_ddr_drain = 0; m_ddr_beats = 0;
        end else if (m_ddr_act) begin
            bend = 0;
            if (d_hs) begin
                m_ddr_beats++;
                bend = (m_ddr_beats % BURST) == 0;
            end
            if (bend && m_ddr_beats == DDR_BEATS) begin
                m_ddr_act = 0; m_ddr_fin = 1; m_ddr_drain = 0;
            end else if (bend && (m_ddr_drain || ab)) begin
                m_ddr_act = 0; m_ddr_drain = 0;
            end else if (ab && !m_ddr_drain) begin
                if ((m_ddr_beats % BURST) == 0 && !d_hs) m_ddr_act = 0;
                else m_ddr_drain = 1;
            end
        end

        @(posedge clk_sys);
        #1;
        cyc++;
        check_val("sdr_we", sdr_we, m_sdr_act);
        check_val("ddr_we", ddr_we, m_ddr_act);
        check_val("busy", busy, m_sdr_act || m_ddr_act);
        check_val("done", done, m_sdr_fin && m_ddr_fin);
        check_val("progress", progress, exp_progress());
        check_val("burstcnt", ddr_burstcnt, BURST);
        if (!m_ddr_act) check_val("ddr_be_off", ddr_be, 8'h00);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = ($urandom_range(0, 1) == 1);
        abort = 1'b0;
        @(posedge clk_sys);
        #1;
        cyc++;
        model_reset();
        check_val("rst_sdr_we", sdr_we, 0);
        check_val("rst_ddr_we", ddr_we, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_sdr_addr", sdr_addr, 0);
        check_val("rst_ddr_addr", ddr_addr, 0);
        check_val("rst_progress", progress, 0);
        check_val("rst_ddr_be", ddr_be, 0);
        check_val("rst_burstcnt", ddr_burstcnt, BURST);
        reset = 1'b0;
        start = 1'b0;
    endtask

    initial begin
        int c0, t_sdr_end;
        model_reset();
        repeat (3) @(posedge clk_sys);
        #1;
        do_reset();

        // Simultaneous start and abort while idle: nothing starts.
        step(1, 1, 1, 0);
        step(0, 0, 1, 0);

        // Free run with no backpressure.
        c0 = cyc;
        t_sdr_end = 0;
        step(1, 0, 1, 0);
        for (int i = 0; i < 1100 && !done; i++) begin
            step(0, 0, 1, 0);
            if (!sdr_we && t_sdr_end == 0) t_sdr_end = cyc - c0;
        end
        check_val("free_done", done, 1);
        check_val("free_done_cycle", cyc - c0, 1025);
        check_val("free_sdr_end_cycle", t_sdr_end, 257);
        check_val("free_progress", progress, 8'hFF);

        // Restart from done under backpressure, with ignored mid-run starts.
        obs_sdr = 0;
        obs_ddr = 0;
        step(1, 0, 0, 1);
        check_val("done_drop", done, 0);
        for (int i = 0; i < 8000 && !done; i++)
            step($urandom_range(0, 15) == 0, 0, (i % 3) == 0, $urandom_range(0, 1) == 1);
        check_val("bp_done", done, 1);
        check_val("bp_sdr_xfers", obs_sdr, SDR_WORDS);
        check_val("bp_ddr_beats", obs_ddr, DDR_BEATS);

        // Abort after two beats of the burst at ddr_addr 40.
        step(1, 0, 1, 0);
        for (int i = 0; i < 100 && m_ddr_beats < 42; i++) step(0, 0, 1, 0);
        check_val("abort_pos", ddr_addr, 40);
        step(0, 1, 1, 0);
        check_val("abort_sdr_we", sdr_we, 0);
        for (int i = 0; i < 20 && busy; i++) step(0, 0, 1, 0);
        check_val("abort_beats", m_ddr_beats, 44);
        check_val("abort_idle", busy, 0);
        check_val("abort_done", done, 0);
        step(0, 0, 1, 0);
        step(1, 0, 1, 0);
        check_val("restart_sdr", sdr_addr, 0);
        check_val("restart_ddr", ddr_addr, 0);

        // Reset in the middle of a burst.
        for (int i = 0; i < 200 && m_ddr_beats < 101; i++) step(0, 0, 1, 0);
        check_val("reset_pos", ddr_addr, 100);
        do_reset();

        // Random traffic with random starts and aborts.
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 7) == 0, $urandom_range(0, 63) == 0,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_clear_ctrl.md
# mem_clear_ctrl

Sequencer that clears the SDRAM and DDR3 address spaces while the menu core runs, so that cores loaded afterwards start with zeroed memory. It drives the write-request side of the SDRAM controller and the DDR3 write port with handshaked, backpressure-aware address sweeps. It also reports busy, done and progress to the top level. Write data is zero and the top level ties it off; this block owns only address, strobes and burst sequencing.

## Interface
Parameters:
- SDR_AW, 25: SDRAM word-address width; sweep covers 0 .. 2^SDR_AW-1. Must be ≥ 8.
- DDR_AW, 29: DDR3 64-bit-word address width. Must be ≥ 8 + log2(DDR_BURST).
- DDR_BURST, 8: beats per DDR3 burst; power of two, 1..128.

Ports:
- clk_sys  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  pulse: begin a clear of both memories
- abort  in  1  pulse: stop clearing at the next safe point
- sdr_addr  out  SDR_AW  SDRAM word address
- sdr_we  out  1  SDRAM write request (level)
- sdr_ready  in  1  SDRAM accepts request this cycle
- ddr_addr  out  DDR_AW  DDR3 burst start address, burst-aligned
- ddr_burstcnt  out  8  constant DDR_BURST
- ddr_be  out  8  8'hFF while ddr_we, else 0
- ddr_we  out  1  DDR3 write beat valid
- ddr_busy  in  1  DDR3 stall
- busy  out  1  any channel active or draining
- done  out  1  both memories fully cleared
- progress  out  8  completion, 0..255

## Operation
- Two independent channel FSMs, SDR and DDR. Each has states IDLE, RUN, DRAIN (DDR only) and DONE.
- start, accepted only when both channels are in IDLE or DONE:
  - both channels go to RUN with address 0;
  - done clears.
  - start in any other state is ignored.
- SDR transfer occurs on a cycle with sdr_we && sdr_ready. sdr_addr increments the next cycle.
  - sdr_we stays high back-to-back.
  - After the transfer at 2^SDR_AW-1, the channel goes to DONE and sdr_we drops.
- DDR beat occurs on a cycle with ddr_we && !ddr_busy. A beat counter counts 0..DDR_BURST-1.
  - ddr_addr, ddr_burstcnt and ddr_be are held stable for the whole burst, including stalls.
  - After the last beat, ddr_addr += DDR_BURST.
  - After the last beat of the final burst (ddr_addr = 2^DDR_AW - DDR_BURST), the channel goes to DONE.
- abort while running:
  - SDR: drops sdr_we the next cycle. A transfer coinciding with the abort cycle still counts. Channel goes to IDLE.
  - DDR: if beat counter = 0 and no beat is in progress, drops ddr_we the next cycle and goes to IDLE. Otherwise enters DRAIN, finishes the remaining beats of the current burst, then drops ddr_we and goes to IDLE.
  - done stays 0.
- start and abort in the same cycle: abort wins, start ignored.
- busy = any channel in RUN or DRAIN.
- done = both channels in DONE. It holds until the next accepted start or reset.
- progress = min(sdr_addr[SDR_AW-1 -: 8], ddr_addr[DDR_AW-1 -: 8]). A channel in DONE contributes 8'hFF.
- Reset mid-operation truncates any DDR burst. This is legal because the DDR3 port shares the reset.

## Timing
- Reset values:
  - sdr_we = ddr_we = busy = done = 0;
  - sdr_addr = ddr_addr = 0;
  - progress = 0;
  - ddr_be = 0;
  - ddr_burstcnt = DDR_BURST.
- start sampled in cycle n: sdr_we and ddr_we are high in n+1 with address 0, and busy is high in n+1.
- SDR throughput: 1 word/cycle with sdr_ready held high.
- DDR throughput: 1 beat/cycle with ddr_busy low. There are no idle cycles between bursts.
- A channel finishing at its last handshake in cycle m: its we is low in m+1. done rises in m+1 of whichever channel finishes last, and busy falls in the same cycle.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
Parameters: SDR_AW=8, DDR_AW=10, DDR_BURST=4.
- **Free run.** Reset, then start at cycle 0 with sdr_ready=1 and ddr_busy=0.
  - SDR: 256 transfers at addresses 0..255 in cycles 1..256.
  - DDR: 1024 beats; ddr_addr steps 0, 4, 8 … 1020, each held for 4 cycles.
  - Completion: done=1 and busy=0 at cycle 1025; progress=8'hFF.
- **Backpressure.** sdr_ready high every 3rd cycle; ddr_busy pseudo-random 50%.
  - Address, burstcnt and be are stable through every stall.
  - Exactly 256 SDR transfers and 1024 DDR beats occur, with no address skipped or repeated.
- **Abort mid-burst.** Assert abort after beat 2 of the burst at ddr_addr=40.
  - DDR: beats 3 and 4 complete, then ddr_we=0.
  - SDR: sdr_we=0 the cycle after abort.
  - Status: busy falls after the last beat; done stays 0.
  - A following start restarts both channels at address 0.
- **Start gating.** start mid-run has no effect on addresses. start while done=1 drops done in the next cycle and restarts from 0.
- **Reset mid-run.** Assert reset at ddr_addr=100 beat 1. Next cycle all outputs are at their reset values.
- **Simultaneous events.** start and abort in the same cycle while IDLE: no we asserted and busy stays 0.
